// File: rtl/buffer_with_header_mc_pkg.sv
// Shared definitions for the multi-channel header packer: FSM state
// encoding and the derivations of slice width and header length.
package buffer_with_header_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Number of spare high-order bits per channel word that carry metadata.
    function automatic int pack_width(int data_width, int data_width_used);
        return data_width - data_width_used;
    endfunction

    // Number of input vectors needed to emit the whole metadata word.
    function automatic int hdr_strobes(int meta_width, int pack_w, int num_chan);
        if (pack_w <= 0 || num_chan <= 0) begin
            return 0;
        end
        return meta_width / (pack_w * num_chan);
    endfunction

    // Legal parameter combination: spare bits exist, 1..4 channels and the
    // metadata splits into a whole number of header vectors.
    function automatic bit cfg_ok(int data_width, int data_width_used,
                                  int meta_width, int num_chan);
        int pw;
        pw = data_width - data_width_used;
        if (data_width_used <= 0 || pw <= 0) begin
            return 1'b0;
        end
        if (num_chan < 1 || num_chan > 4) begin
            return 1'b0;
        end
        if ((meta_width % (pw * num_chan)) != 0) begin
            return 1'b0;
        end
        return (meta_width / (pw * num_chan)) >= 1;
    endfunction

endpackage

// File: rtl/buffer_with_header_mc_if.sv
// Control, configuration and sample-stream bundle of the header packer.
// The master side drives control and samples; the slave side is the packer.
interface buffer_with_header_mc_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int META_WIDTH  = 128,
    parameter int NUM_CHAN    = 2,
    parameter int COUNT_WIDTH = 16
);
    logic                           enable;
    logic                           init;
    logic [META_WIDTH-1:0]          meta_data;
    logic [COUNT_WIDTH-1:0]         num_samples;
    logic                           sign_ext;
    logic [NUM_CHAN*DATA_WIDTH-1:0] data_in;
    logic                           strobe_in;
    logic [NUM_CHAN*DATA_WIDTH-1:0] data_out;
    logic                           strobe_out;
    logic                           header_active;
    logic                           done;
    logic                           truncated;

    modport master (
        output enable, init, meta_data, num_samples, sign_ext, data_in, strobe_in,
        input  data_out, strobe_out, header_active, done, truncated
    );

    modport slave (
        input  enable, init, meta_data, num_samples, sign_ext, data_in, strobe_in,
        output data_out, strobe_out, header_active, done, truncated
    );
endinterface

// File: rtl/buffer_with_header_mc_header_pack_lane.sv
// Per-channel word builder: keeps the used sample bits and fills the spare
// high bits with a metadata slice (header) or zero/sign fill (body).
module header_pack_lane
    import buffer_with_header_mc_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_WIDTH_USED = 12,
    localparam int PACK_WIDTH     = pack_width(DATA_WIDTH, DATA_WIDTH_USED)
) (
    input  logic [PACK_WIDTH-1:0] slice,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic                  hdr_sel,
    input  logic                  sign_ext,
    output logic [DATA_WIDTH-1:0] word
);

    // Spare-bit fill used once the header has been emitted.
    function automatic logic [PACK_WIDTH-1:0] fill_high(input logic msb,
                                                        input logic ext);
        return ext ? {PACK_WIDTH{msb}} : {PACK_WIDTH{1'b0}};
    endfunction

    // Incoming bits above the used field are discarded by design.
    logic unused_hi;
    assign unused_hi = ^sample[DATA_WIDTH-1:DATA_WIDTH_USED];

    // Assemble the output word: high field selected by header phase.
    always_comb begin
        word = {hdr_sel ? slice : fill_high(sample[DATA_WIDTH_USED-1], sign_ext),
                sample[DATA_WIDTH_USED-1:0]};
    end

endmodule

// File: rtl/buffer_with_header_mc.sv
// Multi-channel header packer: embeds a latched metadata word in the spare
// high bits of the first HDR_STROBES sample vectors of a burst, then pads
// the high bits with zeros or sign, and stops after a programmed length.
module buffer_with_header_mc
    import buffer_with_header_mc_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_WIDTH_USED = 12,
    parameter int META_WIDTH      = 128,
    parameter int NUM_CHAN        = 2,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    buffer_with_header_mc_if.slave bus
);

    localparam int PACK_WIDTH  = pack_width(DATA_WIDTH, DATA_WIDTH_USED);
    localparam int HDR_STROBES = hdr_strobes(META_WIDTH, PACK_WIDTH, NUM_CHAN);
    localparam int LANE_SHIFT  = NUM_CHAN * PACK_WIDTH;
    localparam int HCNT_W      = $clog2(HDR_STROBES) + 1;
    localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(HDR_STROBES - 1);

    if (!cfg_ok(DATA_WIDTH, DATA_WIDTH_USED, META_WIDTH, NUM_CHAN)) begin : g_bad_cfg
        $error("buffer_with_header_mc: illegal DATA_WIDTH/DATA_WIDTH_USED/META_WIDTH/NUM_CHAN");
    end

    state_t                         state;
    state_t                         state_nxt;
    logic [META_WIDTH-1:0]          hold_meta;
    logic [COUNT_WIDTH-1:0]         count;
    logic [COUNT_WIDTH-1:0]         count_inc;
    logic [COUNT_WIDTH-1:0]         num_lat;
    logic [HCNT_W-1:0]              hdr_cnt;
    logic                           sign_lat;
    logic                           in_header;
    logic                           accept;
    logic                           last_vec;
    logic                           hdr_last;
    logic [NUM_CHAN*DATA_WIDTH-1:0] lane_word;

    logic [NUM_CHAN*DATA_WIDTH-1:0] data_p1;
    logic                           vld_p1;
    logic                           hdr_p1;
    logic                           done_p1;
    logic                           trunc_p1;
    logic                           vld_nxt;
    logic                           hdr_nxt;
    logic                           done_nxt;
    logic                           trunc_nxt;

    // A strobe is only taken while a burst is running; init wins over it.
    assign in_header = (state == ST_HEADER);
    assign accept    = bus.enable && !bus.init && bus.strobe_in &&
                       (state == ST_HEADER || state == ST_BODY);
    assign count_inc = count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    assign last_vec  = accept && (num_lat != '0) && (count_inc == num_lat);
    assign hdr_last  = (hdr_cnt == HDR_LAST);

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_lane
        header_pack_lane #(
            .DATA_WIDTH      (DATA_WIDTH),
            .DATA_WIDTH_USED (DATA_WIDTH_USED)
        ) u_lane (
            .slice    (hold_meta[c*PACK_WIDTH +: PACK_WIDTH]),
            .sample   (bus.data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .hdr_sel  (in_header),
            .sign_ext (sign_lat),
            .word     (lane_word[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enable freezes, init restarts, accepted strobes advance.
    always_comb begin
        state_nxt = state;
        if (!bus.enable) begin
            state_nxt = state;
        end else if (bus.init) begin
            state_nxt = ST_HEADER;
        end else if (accept) begin
            if (last_vec) begin
                state_nxt = ST_DONE;
            end else if (in_header && hdr_last) begin
                state_nxt = ST_BODY;
            end
        end
    end

    // Output decode for the registered status flags.
    always_comb begin
        vld_nxt   = accept;
        hdr_nxt   = accept && in_header;
        done_nxt  = last_vec;
        trunc_nxt = bus.enable && bus.init && in_header;
    end

    // Stage p1: output registers, metadata shifter and burst counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            hdr_p1    <= 1'b0;
            done_p1   <= 1'b0;
            trunc_p1  <= 1'b0;
            hold_meta <= '0;
            count     <= '0;
            hdr_cnt   <= '0;
            num_lat   <= '0;
            sign_lat  <= 1'b0;
        end else begin
            vld_p1   <= vld_nxt;
            hdr_p1   <= hdr_nxt;
            done_p1  <= done_nxt;
            trunc_p1 <= trunc_nxt;
            if (accept) begin
                data_p1 <= lane_word;
            end
            if (bus.enable) begin
                if (bus.init) begin
                    hold_meta <= bus.meta_data;
                    count     <= '0;
                    hdr_cnt   <= '0;
                    num_lat   <= bus.num_samples;
                    sign_lat  <= bus.sign_ext;
                end else if (accept) begin
                    count <= count_inc;
                    if (in_header) begin
                        hold_meta <= hold_meta >> LANE_SHIFT;
                        hdr_cnt   <= hdr_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.data_out      = data_p1;
    assign bus.strobe_out    = vld_p1;
    assign bus.header_active = hdr_p1;
    assign bus.done          = done_p1;
    assign bus.truncated     = trunc_p1;

endmodule

// File: tb/tb_buffer_with_header_mc.sv
// Directed bench for buffer_with_header_mc: each table row gives one cycle of
// inputs and the outputs expected just after the following clock edge.
module tb_buffer_with_header_mc;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    buffer_with_header_mc_if bus ();

    buffer_with_header_mc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string        name;
        logic         rst;
        logic         en;
        logic         ini;
        logic         stb;
        logic         sgn;
        logic [15:0]  num;
        logic [127:0] meta;
        logic [31:0]  din;
        logic         x_stb;
        logic         x_hdr;
        logic         x_done;
        logic         x_trunc;
        logic [31:0]  x_data;
    } vec_t;

    localparam logic [127:0] M1 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] M2 = 128'h11223344_55667788_99AABBCC_DDEEFFA5;

    vec_t         vecs[$];
    int           total = 0;
    int           bad   = 0;
    logic [127:0] cur_meta = M1;
    logic [15:0]  cur_num  = 16'd0;
    logic         cur_sgn  = 1'b0;
    logic [31:0]  last_data = 32'h0;

    // Header vector k: slice 2k in ch0, slice 2k+1 in ch1 (4-bit slices).
    function automatic logic [31:0] hdr_vec(input logic [127:0] m, input int k,
                                            input logic [11:0] s0, input logic [11:0] s1);
        logic [3:0] n0;
        logic [3:0] n1;
        n0 = m[8*k +: 4];
        n1 = m[8*k+4 +: 4];
        return {n1, s1, n0, s0};
    endfunction

    task automatic add(input string nm, input logic r, input logic e, input logic i,
                       input logic s, input logic [31:0] d, input logic xs,
                       input logic xh, input logic xd, input logic xt,
                       input logic [31:0] xdat);
        vec_t v;
        if (r) begin
            last_data = 32'h0;
        end else if (xs) begin
            last_data = xdat;
        end
        v.name = nm; v.rst = r; v.en = e; v.ini = i; v.stb = s;
        v.sgn = cur_sgn; v.num = cur_num; v.meta = cur_meta; v.din = d;
        v.x_stb = xs; v.x_hdr = xh; v.x_done = xd; v.x_trunc = xt;
        v.x_data = last_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[row %0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.init        = 1'b0;
        bus.meta_data   = '0;
        bus.num_samples = '0;
        bus.sign_ext    = 1'b0;
        bus.data_in     = '0;
        bus.strobe_in   = 1'b0;

        // Reset state, then a strobe in IDLE is ignored.
        add("rst0", 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        add("rst1", 1, 1, 0, 1, 32'h0123_0123, 0, 0, 0, 0, 32'h0);
        add("idle_stb", 0, 1, 0, 1, 32'h0123_0123, 0, 0, 0, 0, 32'h0);

        // Unlimited burst of 20 vectors; high input nibbles must be dropped.
        add("a_init", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            if (k < 16)
                add("a_hdr", 0, 1, 0, 1, 32'hA123_B123, 1, 1, 0, 0, hdr_vec(M1, k, 12'h123, 12'h123));
            else
                add("a_body", 0, 1, 0, 1, 32'hA123_B123, 1, 0, 0, 0, 32'h0123_0123);
        end
        add("a_gap", 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);

        // Sign extension on, then off.
        cur_sgn = 1'b1;
        add("b_init", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 16; k++)
            add("b_hdr", 0, 1, 0, 1, 32'h0000_0000, 1, 1, 0, 0, hdr_vec(M1, k, 12'h000, 12'h000));
        add("b_sx0", 0, 1, 0, 1, 32'h07FF_0800, 1, 0, 0, 0, 32'h07FF_F800);
        add("b_sx1", 0, 1, 0, 1, 32'h5800_C7FF, 1, 0, 0, 0, 32'hF800_07FF);
        cur_sgn = 1'b0;
        add("b_init0", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 16; k++)
            add("b_hdr0", 0, 1, 0, 1, 32'h0000_0000, 1, 1, 0, 0, hdr_vec(M1, k, 12'h000, 12'h000));
        add("b_zx", 0, 1, 0, 1, 32'h07FF_0800, 1, 0, 0, 0, 32'h07FF_0800);

        // Length-limited burst of 5 ends inside the header.
        cur_num = 16'd5;
        add("c_init", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 5; k++)
            add("c_vec", 0, 1, 0, 1, 32'h0123_0123, 1, 1, (k == 4), 0, hdr_vec(M1, k, 12'h123, 12'h123));
        add("c_6th", 0, 1, 0, 1, 32'h0123_0123, 0, 0, 0, 0, 32'h0);
        add("c_7th", 0, 1, 0, 1, 32'h0456_0456, 0, 0, 0, 0, 32'h0);
        add("c_reinit", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++)
            add("c_re_vec", 0, 1, 0, 1, 32'h0123_0123, 1, 1, 0, 0, hdr_vec(M1, k, 12'h123, 12'h123));

        // Init after 3 header strobes: truncated, new metadata from slice 0.
        cur_num  = 16'd0;
        cur_meta = M2;
        add("d_trunc", 0, 1, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0);
        add("d_new0", 0, 1, 0, 1, 32'h0123_0123, 1, 1, 0, 0, hdr_vec(M2, 0, 12'h123, 12'h123));
        // init with coincident strobe: strobe dropped.
        add("d_init_stb", 0, 1, 1, 1, 32'h0123_0123, 0, 0, 0, 1, 32'h0);
        add("d_s0", 0, 1, 0, 1, 32'h0321_0654, 1, 1, 0, 0, hdr_vec(M2, 0, 12'h654, 12'h321));
        // enable low across two strobes: nothing emitted, header not advanced.
        add("d_en_lo0", 0, 0, 0, 1, 32'h0AAA_0BBB, 0, 0, 0, 0, 32'h0);
        add("d_en_lo1", 0, 0, 1, 1, 32'h0AAA_0BBB, 0, 0, 0, 0, 32'h0);
        add("d_s1", 0, 1, 0, 1, 32'h0321_0654, 1, 1, 0, 0, hdr_vec(M2, 1, 12'h654, 12'h321));

        // Reset inside BODY, strobes ignored until a new init.
        cur_meta = M1;
        add("e_init", 0, 1, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0);
        for (int k = 0; k < 17; k++) begin
            if (k < 16)
                add("e_hdr", 0, 1, 0, 1, 32'h0123_0123, 1, 1, 0, 0, hdr_vec(M1, k, 12'h123, 12'h123));
            else
                add("e_body", 0, 1, 0, 1, 32'h0123_0123, 1, 0, 0, 0, 32'h0123_0123);
        end
        add("e_rst", 1, 1, 0, 1, 32'h0123_0123, 0, 0, 0, 0, 32'h0);
        add("e_post_rst", 0, 1, 0, 1, 32'h0123_0123, 0, 0, 0, 0, 32'h0);
        add("e_init2", 0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        add("e_vec", 0, 1, 0, 1, 32'h0123_0123, 1, 1, 0, 0, hdr_vec(M1, 0, 12'h123, 12'h123));

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst;
            bus.enable      = vecs[i].en;
            bus.init        = vecs[i].ini;
            bus.strobe_in   = vecs[i].stb;
            bus.sign_ext    = vecs[i].sgn;
            bus.num_samples = vecs[i].num;
            bus.meta_data   = vecs[i].meta;
            bus.data_in     = vecs[i].din;
            @(posedge clock);
            #1;
            chk({vecs[i].name, ".strobe_out"}, i, {31'b0, bus.strobe_out}, {31'b0, vecs[i].x_stb});
            chk({vecs[i].name, ".header_active"}, i, {31'b0, bus.header_active}, {31'b0, vecs[i].x_hdr});
            chk({vecs[i].name, ".done"}, i, {31'b0, bus.done}, {31'b0, vecs[i].x_done});
            chk({vecs[i].name, ".truncated"}, i, {31'b0, bus.truncated}, {31'b0, vecs[i].x_trunc});
            chk({vecs[i].name, ".data_out"}, i, bus.data_out, vecs[i].x_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
